regf_sb: RTL
============

// Module: regf_sb
// PURPOSE
//  Parametrised register file for the proc core: NRD combinational read ports,
//  two write ports (ALU writeback, load writeback), optional same-cycle
//  write-to-read bypass, per-register pending (scoreboard) bits for in-flight
//  loads. Index 0 is $zero (RO, reads 0); index 2**AW-1 is $pc (RO, reads i_pc).
//  Sits between decode (reads/reservations) and writeback.
// PARAMETERS
//  DW      32  data width
//  AW      6   address width; 2**AW registers incl. $zero and $pc
//  NRD     3   number of read ports
//  BYPASS  1   1: reads forward same-cycle write data; 0: reads see stored value
// PORTS
//  i_clk       in   1       clock, rising edge
//  i_rst_n     in   1       asynchronous active-low reset
//  i_pc        in   DW      value returned for reads of $pc
//  i_raddr     in   NRD*AW  read addresses, port k at [k*AW +: AW]
//  o_rdata     out  NRD*DW  read data, port k at [k*DW +: DW]
//  o_rbusy     out  NRD     port k's register has a pending write
//  i_we0       in   1       ALU write enable
//  i_waddr0    in   AW      ALU write address
//  i_wdata0    in   DW      ALU write data
//  i_we1       in   1       load write enable
//  i_waddr1    in   AW      load write address
//  i_wdata1    in   DW      load write data
//  i_rsv       in   1       reserve: set pending bit of i_rsv_addr
//  i_rsv_addr  in   AW      register to reserve
//  o_npend     out  AW      count of registers currently pending
// BEHAVIOUR
//  Reset (i_rst_n=0, async): all storage regs 0, all pending bits 0, o_npend 0.
//   Reads during reset: o_rdata = 0 except $pc reads = i_pc; o_rbusy = 0.
//  Writes: registered on rising i_clk. Writes to $zero or $pc are dropped
//   (no storage change, no pending change).
//  Both write ports, same address, same cycle: port 1 (load) data is stored.
//  Read mux per port, priority: $zero -> 0; $pc -> i_pc; BYPASS=1 and
//   i_we1 hit -> i_wdata1; BYPASS=1 and i_we0 hit -> i_wdata0; else stored.
//   Read latency 0 (combinational); BYPASS=0 gives old value until next edge.
//  Pending bits, per register r, next state:
//   set if i_rsv && i_rsv_addr==r (r not $zero/$pc, else ignored);
//   else cleared if a write (either port) targets r; else hold.
//   Reserve and write to same r in same cycle: data stored, bit ends SET.
//  o_rbusy[k] = pending[raddr_k], except 0 for $zero/$pc, and when BYPASS=1
//   a same-cycle write to raddr_k forces 0 (the forwarded data is final).
//  o_npend: registered population count of pending bits, updated with them;
//   max value 2**AW-2, never wraps.
//  Re-reserving an already pending register: bit stays set, count unchanged.
//  Mid-operation reset clears pending bits; in-flight load writes after reset
//   still store data normally.
// TESTING
//  Reset, then read all ports at 0, 63, 5 with i_pc=0x400 -> 0, 0x400, 0; busy 0.
//  we0 r5=0xDEAD, raddr0=5 same cycle, BYPASS=1 -> 0xDEAD same cycle; BYPASS=0
//   -> 0 same cycle, 0xDEAD next cycle.
//  we0 r7=0x11 and we1 r7=0x22 same cycle -> r7 reads 0x22; writes to r0,r63
//   -> r0 reads 0, r63 reads i_pc.
//  rsv r9 -> o_rbusy on r9 =1, o_npend=1; load write r9=0x99 -> busy 0 next
//   cycle, npend 0; rsv+write r9 same cycle -> data 0x99, busy 1, npend 1.
//  Reserve r1..r4, pulse i_rst_n low mid-cycle -> busy/npend/regs 0 immediately.
//  Random writes/reserves vs reference model over 10k cycles -> all reads match.

Source files
------------

// File: rtl/regf_sb_if.sv
// Bus bundle for regf_sb: read ports, the two writeback ports, reservation
// port and the pending-count output.
interface regf_sb_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 6,
  parameter int unsigned NRD = 3
);
  logic [DW-1:0]     i_pc;
  logic [NRD*AW-1:0] i_raddr;
  logic [NRD*DW-1:0] o_rdata;
  logic [NRD-1:0]    o_rbusy;
  logic              i_we0;
  logic [AW-1:0]     i_waddr0;
  logic [DW-1:0]     i_wdata0;
  logic              i_we1;
  logic [AW-1:0]     i_waddr1;
  logic [DW-1:0]     i_wdata1;
  logic              i_rsv;
  logic [AW-1:0]     i_rsv_addr;
  logic [AW-1:0]     o_npend;

  modport slave (
    input  i_pc, i_raddr, i_we0, i_waddr0, i_wdata0,
           i_we1, i_waddr1, i_wdata1, i_rsv, i_rsv_addr,
    output o_rdata, o_rbusy, o_npend
  );

  modport master (
    output i_pc, i_raddr, i_we0, i_waddr0, i_wdata0,
           i_we1, i_waddr1, i_wdata1, i_rsv, i_rsv_addr,
    input  o_rdata, o_rbusy, o_npend
  );
endinterface

// File: rtl/regf_sb.sv
// Register file with $zero/$pc aliases, two writeback ports, optional
// same-cycle forwarding and per-register pending bits for in-flight loads.
module regf_sb #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 6,
  parameter int unsigned NRD    = 3,
  parameter int unsigned BYPASS = 1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  regf_sb_if.slave  bus
);
  localparam int unsigned   NREG     = 1 << AW;
  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
  localparam logic [AW-1:0] PC_IDX   = {AW{1'b1}};
  localparam logic          BYP_EN   = (BYPASS != 0);

  logic [DW-1:0]     regs_q [NREG];
  logic [DW-1:0]     regs_d [NREG];
  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_d;
  logic [AW-1:0]     npend_q;
  logic [AW-1:0]     npend_d;
  logic [NREG-1:0]   wr0_hit_s;
  logic [NREG-1:0]   wr1_hit_s;
  logic [NREG-1:0]   rsv_hit_s;
  logic [NRD*DW-1:0] rdata_s;
  logic [NRD-1:0]    rbusy_s;

  function automatic logic is_fixed(input logic [AW-1:0] a);
    return (a == ZERO_IDX) || (a == PC_IDX);
  endfunction

  function automatic logic [AW-1:0] popcount(input logic [NREG-1:0] v);
    logic [AW-1:0] cnt;
    cnt = {AW{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + {{(AW-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Decode write/reserve targets; $zero and $pc never match.
  always_comb begin
    wr0_hit_s = {NREG{1'b0}};
    wr1_hit_s = {NREG{1'b0}};
    rsv_hit_s = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      wr0_hit_s[r] = bus.i_we0 && (bus.i_waddr0 == AW'(r)) && !is_fixed(AW'(r));
      wr1_hit_s[r] = bus.i_we1 && (bus.i_waddr1 == AW'(r)) && !is_fixed(AW'(r));
      rsv_hit_s[r] = bus.i_rsv && (bus.i_rsv_addr == AW'(r)) && !is_fixed(AW'(r));
    end
  end

  // Next storage and pending state; a reserve beats a clearing write.
  always_comb begin
    pend_d = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = wr1_hit_s[r] ? bus.i_wdata1 :
                  wr0_hit_s[r] ? bus.i_wdata0 : regs_q[r];
      pend_d[r] = rsv_hit_s[r] ? 1'b1 :
                  (wr0_hit_s[r] || wr1_hit_s[r]) ? 1'b0 : pend_q[r];
    end
    npend_d = popcount(pend_d);
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= {DW{1'b0}};
      end
      pend_q  <= {NREG{1'b0}};
      npend_q <= {AW{1'b0}};
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pend_q  <= pend_d;
      npend_q <= npend_d;
    end
  end

  // Read muxes; forwarding is suppressed while reset is held so reads stay 0.
  always_comb begin
    logic [AW-1:0] ra;
    logic          h0;
    logic          h1;
    rdata_s = {(NRD*DW){1'b0}};
    rbusy_s = {NRD{1'b0}};
    ra      = {AW{1'b0}};
    h0      = 1'b0;
    h1      = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.i_raddr[k*AW +: AW];
      h1 = BYP_EN && i_rst_n && bus.i_we1 && (bus.i_waddr1 == ra);
      h0 = BYP_EN && i_rst_n && bus.i_we0 && (bus.i_waddr0 == ra);
      if (ra == ZERO_IDX) begin
        rdata_s[k*DW +: DW] = {DW{1'b0}};
        rbusy_s[k]          = 1'b0;
      end else if (ra == PC_IDX) begin
        rdata_s[k*DW +: DW] = bus.i_pc;
        rbusy_s[k]          = 1'b0;
      end else if (h1) begin
        rdata_s[k*DW +: DW] = bus.i_wdata1;
        rbusy_s[k]          = 1'b0;
      end else if (h0) begin
        rdata_s[k*DW +: DW] = bus.i_wdata0;
        rbusy_s[k]          = 1'b0;
      end else begin
        rdata_s[k*DW +: DW] = regs_q[ra];
        rbusy_s[k]          = pend_q[ra];
      end
    end
  end

  assign bus.o_rdata = rdata_s;
  assign bus.o_rbusy = rbusy_s;
  assign bus.o_npend = npend_q;
endmodule
